// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared types, constants and counter helper for pc_gen_unit
package pc_gen_pkg;

    typedef logic [1:0] bht_ctr_t;

    localparam bht_ctr_t BHT_CTR_RESET = 2'b01;
    localparam bht_ctr_t CTR_STRONG_T  = 2'b11;
    localparam bht_ctr_t CTR_STRONG_NT = 2'b00;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_MISPRED,
        SEL_JALR,
        SEL_PRED,
        SEL_SEQ
    } next_pc_sel_e;

    // Saturating 2-bit counter step toward the resolved outcome.
    function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_STRONG_T) ? ctr : ctr + 2'b01;
        end
        return (ctr == CTR_STRONG_NT) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// rtl/bht_2bit.sv - direct-mapped table of 2-bit counters, async read, sync update
module bht_2bit
    import pc_gen_pkg::*;
#(
    parameter  int BHT_ENTRIES = 16,
    localparam int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             reset_n_in,
    input  logic [IDX_W-1:0] rd_idx_i,
    output bht_ctr_t         rd_ctr_o,
    input  logic             upd_valid_i,
    input  logic [IDX_W-1:0] upd_idx_i,
    input  logic             upd_taken_i
);

    bht_ctr_t ctr_q [BHT_ENTRIES];
    bht_ctr_t ctr_d;

    assign ctr_d    = ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    // Read comes straight from the registers, so a same-cycle update is not visible.
    assign rd_ctr_o = ctr_q[rd_idx_i];

    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr_q[i] <= BHT_CTR_RESET;
            end
        end else if (upd_valid_i) begin
            ctr_q[upd_idx_i] <= ctr_d;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// rtl/pc_gen_unit.sv - PC register and next-fetch-address select; PC_GEN_BPRED_EN adds the BHT
module pc_gen_unit
    import pc_gen_pkg::*;
#(
    parameter  int             XLEN        = 32,
    parameter  logic [XLEN-1:0] BOOT_ADDR  = '0,
    parameter  int             BHT_ENTRIES = 16,
    localparam int             BHT_IDX_W   = $clog2(BHT_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset_n_in,
    input  logic            stall_in,
    input  logic            fetch_ready_in,
    output logic            fetch_valid_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus4_out,
    output logic            pred_taken_out,
    input  logic            br_in,
    input  logic            jal_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic            jalr_valid_in,
    input  logic [XLEN-1:0] jalr_target_in,
    input  logic            trap_valid_in,
    input  logic [XLEN-1:0] trap_target_in,
    input  logic            mispredict_in,
    input  logic [XLEN-1:0] correct_pc_in,
    input  logic            upd_valid_in,
    input  logic [XLEN-1:0] upd_pc_in,
    input  logic            upd_taken_in,
    output logic            misaligned_out
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            pred_bit;
    logic [XLEN-1:0] cand;
    next_pc_sel_e    sel;
    logic            misaligned;
    logic            load;
    logic            unused_bits;

`ifdef PC_GEN_BPRED_EN
    bht_ctr_t rd_ctr;

    bht_2bit #(.BHT_ENTRIES(BHT_ENTRIES)) u_bht (
        .clk         (clk),
        .reset_n_in  (reset_n_in),
        .rd_idx_i    (pc_q[BHT_IDX_W+1:2]),
        .rd_ctr_o    (rd_ctr),
        .upd_valid_i (upd_valid_in),
        .upd_idx_i   (upd_pc_in[BHT_IDX_W+1:2]),
        .upd_taken_i (upd_taken_in)
    );

    assign pred_bit    = rd_ctr[1];
    assign unused_bits = ^{rd_ctr[0], upd_pc_in[XLEN-1:BHT_IDX_W+2], upd_pc_in[1:0],
                           jalr_target_in[0]};
`else
    // Backward branches (negative offset) predicted taken, forward not taken.
    assign pred_bit    = imm_in[XLEN-1];
    assign unused_bits = ^{upd_valid_in, upd_pc_in, upd_taken_in, jalr_target_in[0]};
`endif

    assign pc_out          = pc_q;
    assign pc_plus4_out    = pc_q + XLEN'(4);
    assign fetch_valid_out = valid_q;
    assign pred_taken_out  = jal_in | (br_in & pred_bit);
    assign misaligned_out  = misaligned;

    always_comb begin
        sel  = SEL_SEQ;
        cand = pc_plus4_out;
        if (trap_valid_in) begin
            sel  = SEL_TRAP;
            cand = trap_target_in;
        end else if (mispredict_in) begin
            sel  = SEL_MISPRED;
            cand = correct_pc_in;
        end else if (jalr_valid_in) begin
            sel  = SEL_JALR;
            cand = {jalr_target_in[XLEN-1:1], 1'b0};
        end else if (pred_taken_out) begin
            sel  = SEL_PRED;
            cand = pc_q + imm_in;
        end
    end

    // Nothing loads until the first post-reset edge has presented BOOT_ADDR as a valid fetch.
    always_comb begin
        misaligned = valid_q && (sel != SEL_TRAP) && cand[1];
        load       = valid_q && !misaligned &&
                     ((sel == SEL_TRAP) || (sel == SEL_MISPRED) ||
                      (fetch_ready_in && !stall_in));
        pc_d       = load ? cand : pc_q;
    end

    always_ff @(posedge clk or negedge reset_n_in) begin
        if (!reset_n_in) begin
            pc_q    <= BOOT_ADDR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            valid_q <= 1'b1;
        end
    end

endmodule
